// File: rtl/hamming74_pkg.sv
// Hamming(7,4) widths and pure encode/syndrome/correct functions shared by the
// UART link codec. Codeword bit k holds Hamming position k+1.
package hamming74_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SYN_W-1:0]  syn_t;

  function automatic code_t hamming74_encode(input data_t d);
    code_t c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  function automatic syn_t hamming74_syndrome(input code_t c);
    syn_t s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    return s;
  endfunction

  // A non-zero syndrome is the 1-based position of the bit to flip; double
  // errors land on a wrong position and are silently miscorrected.
  function automatic data_t hamming74_correct(input code_t c, input syn_t s);
    code_t fixed;
    fixed = c;
    if (s != '0) fixed[s - 3'd1] = ~fixed[s - 3'd1];
    return {fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

endpackage

// File: rtl/hamming74_codec_counter3.sv
// Free-running 3-bit status counter with enable; done flags the terminal count.
module counter3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [2:0] count,
  output logic       done
);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset in the sensitivity list, so reset acts without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (ena) count <= count + 3'd1;
  end

  assign done = (count == 3'd7);

endmodule

// File: rtl/hamming74_codec.sv
// Hamming(7,4) codec: registered TX encoder, registered single-error-correcting
// RX decoder with decode counter, and a status counter for debug pins.
module hamming74_codec
  import hamming74_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_ena,
  input  logic [DATA_W-1:0] enc_data_in,
  output logic [CODE_W-1:0] enc_code_out,
  output logic              enc_valid_out,
  input  logic              dec_ena,
  input  logic [CODE_W-1:0] dec_code_in,
  output logic [DATA_W-1:0] dec_data_out,
  output logic              dec_valid_out,
  output logic [SYN_W-1:0]  dec_syndrome_out,
  output logic [2:0]        dec_count_out,
  input  logic              cnt_ena,
  output logic [2:0]        cnt_count,
  output logic              cnt_done
);

  syn_t  dec_syn;
  data_t dec_fixed;

  // NOTE: every combinational signal is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    dec_syn   = hamming74_syndrome(dec_code_in);
    dec_fixed = hamming74_correct(dec_code_in, dec_syn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_code_out  <= '0;
      enc_valid_out <= 1'b0;
    end else begin
      enc_valid_out <= enc_ena;
      if (enc_ena) enc_code_out <= hamming74_encode(enc_data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_data_out     <= '0;
      dec_syndrome_out <= '0;
      dec_valid_out    <= 1'b0;
      dec_count_out    <= '0;
    end else begin
      dec_valid_out <= dec_ena;
      if (dec_ena) begin
        dec_data_out     <= dec_fixed;
        dec_syndrome_out <= dec_syn;
        dec_count_out    <= dec_count_out + 3'd1;
      end
    end
  end

  counter3 u_status_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (cnt_ena),
    .count (cnt_count),
    .done  (cnt_done)
  );

endmodule

// File: tb/tb_hamming74_codec.sv
// Directed self-checking bench for hamming74_codec using hand-computed vectors.
module tb_hamming74_codec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enc_ena;
  logic [3:0] enc_data_in;
  logic [6:0] enc_code_out;
  logic       enc_valid_out;
  logic       dec_ena;
  logic [6:0] dec_code_in;
  logic [3:0] dec_data_out;
  logic       dec_valid_out;
  logic [2:0] dec_syndrome_out;
  logic [2:0] dec_count_out;
  logic       cnt_ena;
  logic [2:0] cnt_count;
  logic       cnt_done;

  int total = 0;
  int bad   = 0;

  // Hand-computed codewords for nibbles 0..F.
  logic [6:0] golden [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                              7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

  always #5 clk = ~clk;

  hamming74_codec dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enc_ena          (enc_ena),
    .enc_data_in      (enc_data_in),
    .enc_code_out     (enc_code_out),
    .enc_valid_out    (enc_valid_out),
    .dec_ena          (dec_ena),
    .dec_code_in      (dec_code_in),
    .dec_data_out     (dec_data_out),
    .dec_valid_out    (dec_valid_out),
    .dec_syndrome_out (dec_syndrome_out),
    .dec_count_out    (dec_count_out),
    .cnt_ena          (cnt_ena),
    .cnt_count        (cnt_count),
    .cnt_done         (cnt_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] cw;
    logic [2:0] exp_cnt;

    rst_n = 1'b1; enc_ena = 0; enc_data_in = 0; dec_ena = 0; dec_code_in = 0; cnt_ena = 0;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset mid-run with a pending encode, decode and running counter.
    cnt_ena = 1; tick(); tick(); tick();
    check("cnt_before_reset", 32'(cnt_count), 32'd3);
    enc_ena = 1; enc_data_in = 4'hB; dec_ena = 1; dec_code_in = 7'h55;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_enc_code",  32'(enc_code_out), 32'h0);
    check("rst_enc_valid", 32'(enc_valid_out), 32'h0);
    check("rst_dec_data",  32'(dec_data_out), 32'h0);
    check("rst_dec_valid", 32'(dec_valid_out), 32'h0);
    check("rst_dec_syn",   32'(dec_syndrome_out), 32'h0);
    check("rst_dec_count", 32'(dec_count_out), 32'h0);
    check("rst_cnt",       32'(cnt_count), 32'h0);
    check("rst_cnt_done",  32'(cnt_done), 32'h0);
    tick();
    check("rst_hold_valid", 32'(enc_valid_out), 32'h0);
    enc_ena = 0; dec_ena = 0;
    #2 rst_n = 1'b1;

    // Counter runs 1..7 then wraps; done only at 7.
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_cnt = 3'(i);
      check("cnt_run", 32'(cnt_count), 32'(exp_cnt));
      check("cnt_done", 32'(cnt_done), (i == 7) ? 32'd1 : 32'd0);
    end
    cnt_ena = 0;
    tick(); tick();
    check("cnt_frozen", 32'(cnt_count), 32'd0);
    cnt_ena = 1;
    for (int i = 0; i < 7; i++) tick();
    cnt_ena = 0;
    tick(); tick();
    check("cnt_frozen_at7", 32'(cnt_count), 32'd7);
    check("cnt_done_frozen", 32'(cnt_done), 32'd1);

    // Single encode pulse.
    enc_ena = 1; enc_data_in = 4'hB;
    tick();
    enc_ena = 0; enc_data_in = 4'h0;
    check("enc_B_code", 32'(enc_code_out), 32'h55);
    check("enc_B_valid", 32'(enc_valid_out), 32'd1);
    tick();
    check("enc_valid_one_cycle", 32'(enc_valid_out), 32'd0);
    check("enc_code_hold", 32'(enc_code_out), 32'h55);

    // Back-to-back encode sweep of all nibbles.
    enc_ena = 1;
    for (int i = 0; i < 16; i++) begin
      enc_data_in = 4'(i);
      tick();
      check("enc_sweep_code", 32'(enc_code_out), 32'(golden[i]));
      check("enc_sweep_valid", 32'(enc_valid_out), 32'd1);
    end
    enc_ena = 0;

    // Clean decode.
    dec_ena = 1; dec_code_in = 7'h55;
    tick();
    dec_ena = 0;
    check("dec_clean_data", 32'(dec_data_out), 32'hB);
    check("dec_clean_syn", 32'(dec_syndrome_out), 32'd0);
    check("dec_clean_valid", 32'(dec_valid_out), 32'd1);
    check("dec_clean_count", 32'(dec_count_out), 32'd1);
    tick();
    check("dec_valid_one_cycle", 32'(dec_valid_out), 32'd0);
    check("dec_count_hold", 32'(dec_count_out), 32'd1);

    // Bit 4 flipped.
    dec_ena = 1; dec_code_in = 7'h45;
    tick();
    dec_ena = 0;
    check("dec_err_data", 32'(dec_data_out), 32'hB);
    check("dec_err_syn", 32'(dec_syndrome_out), 32'd5);
    check("dec_err_count", 32'(dec_count_out), 32'd2);

    // Every nibble with every single-bit flip.
    exp_cnt = 3'd2;
    dec_ena = 1;
    for (int d = 0; d < 16; d++) begin
      for (int k = 0; k < 7; k++) begin
        cw = golden[d];
        cw[k] = ~cw[k];
        dec_code_in = cw;
        tick();
        exp_cnt = exp_cnt + 3'd1;
        check("dec_sweep_data", 32'(dec_data_out), 32'(d));
        check("dec_sweep_syn", 32'(dec_syndrome_out), 32'(k + 1));
        check("dec_sweep_count", 32'(dec_count_out), 32'(exp_cnt));
      end
    end
    dec_ena = 0;

    // Fresh reset, then nine consecutive decodes wrap the decode count.
    #2 rst_n = 1'b0;
    #1 check("dec_count_rst", 32'(dec_count_out), 32'd0);
    #2 rst_n = 1'b1;
    dec_ena = 1; dec_code_in = 7'h2A;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_cnt = 3'(i);
      check("wrap_valid", 32'(dec_valid_out), 32'd1);
      check("wrap_count", 32'(dec_count_out), 32'(exp_cnt));
      check("wrap_data", 32'(dec_data_out), 32'h4);
    end
    dec_ena = 0;
    tick();
    check("wrap_valid_drop", 32'(dec_valid_out), 32'd0);
    check("wrap_count_final", 32'(dec_count_out), 32'd1);

    // Simultaneous strobes on all three blocks.
    enc_ena = 1; enc_data_in = 4'h6; dec_ena = 1; dec_code_in = 7'h61 ^ 7'h01; cnt_ena = 1;
    tick();
    enc_ena = 0; dec_ena = 0; cnt_ena = 0;
    check("sim_enc", 32'(enc_code_out), 32'h33);
    check("sim_dec_data", 32'(dec_data_out), 32'hC);
    check("sim_dec_syn", 32'(dec_syndrome_out), 32'd1);
    check("sim_cnt", 32'(cnt_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
